cache_fill_fsm: RTL and testbench

//  Miss-handling controller between one cache (instruction or data) and the shared

---
 rtl/cache_fill_fsm.sv | 111 +++++++++++
 tb/tb_cache_fill_fsm.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_fsm.sv
// Block-fill controller: on a cache miss, streams one word read per cycle to main memory and steers returns into the data array.
// Issue starts the cycle after the miss is accepted; fill waits while memory_busy is high in IDLE; completion is counted purely in returned words.
module cache_fill_fsm #(
  parameter int ADDR_W          = 16,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int OFF_W           = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              memory_busy,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic              mem_enable,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic [OFF_W-1:0]  word_offset,
  output logic              write_tag_array
);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(2 * WORDS_PER_BLOCK - 1));
  localparam logic [OFF_W:0]    WPB_CNT    = (OFF_W + 1)'(WORDS_PER_BLOCK);
  localparam logic [OFF_W-1:0]  LAST_RET   = OFF_W'(WORDS_PER_BLOCK - 1);

  state_t             r_state;
  logic [ADDR_W-1:0]  r_base;
  logic [OFF_W:0]     r_issue_cnt;
  logic [OFF_W-1:0]   r_ret_cnt;
  logic               r_fsm_busy;
  logic               r_mem_enable;
  logic [ADDR_W-1:0]  r_memory_address;

  logic [ADDR_W-1:0]  w_miss_base;
  logic [OFF_W:0]     w_issue_nxt;
  logic [ADDR_W-1:0]  w_issue_off;
  logic               w_issue_more;
  logic               w_ret;
  logic               w_last_ret;

  assign w_miss_base  = miss_address & ALIGN_MASK;
  assign w_issue_nxt  = r_issue_cnt + (OFF_W + 1)'(1);
  assign w_issue_off  = ADDR_W'({w_issue_nxt, 1'b0});
  assign w_issue_more = (w_issue_nxt < WPB_CNT);

  // Returns only count while a fill is live; strays after reset or in IDLE are dropped.
  assign w_ret      = (r_state == FILL) && memory_data_valid;
  assign w_last_ret = w_ret && (r_ret_cnt == LAST_RET);

  assign write_data_array = w_ret;
  assign word_offset      = w_ret ? r_ret_cnt : '0;
  assign write_tag_array  = w_last_ret;

  assign fsm_busy       = r_fsm_busy;
  assign mem_enable     = r_mem_enable;
  assign memory_address = r_memory_address;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= IDLE;
      r_base           <= '0;
      r_issue_cnt      <= '0;
      r_ret_cnt        <= '0;
      r_fsm_busy       <= 1'b0;
      r_mem_enable     <= 1'b0;
      r_memory_address <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (miss_detected && !memory_busy) begin
            r_state          <= FILL;
            r_base           <= w_miss_base;
            r_issue_cnt      <= '0;
            r_ret_cnt        <= '0;
            r_fsm_busy       <= 1'b1;
            r_mem_enable     <= 1'b1;
            r_memory_address <= w_miss_base;
          end
        end
        FILL: begin
          // Output regs hold the next cycle's issue so mem_enable/address come straight from flops.
          if (r_mem_enable) begin
            r_issue_cnt      <= w_issue_nxt;
            r_mem_enable     <= w_issue_more;
            r_memory_address <= w_issue_more ? (r_base + w_issue_off) : '0;
          end
          if (w_ret) begin
            r_ret_cnt <= r_ret_cnt + OFF_W'(1);
          end
          if (w_last_ret) begin
            r_state          <= IDLE;
            r_issue_cnt      <= '0;
            r_ret_cnt        <= '0;
            r_fsm_busy       <= 1'b0;
            r_mem_enable     <= 1'b0;
            r_memory_address <= '0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: latency-modelled main memory plus address/offset scoreboards.
module tb_cache_fill_fsm;

  logic        clk;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_busy;
  logic        memory_data_valid;
  logic        fsm_busy;
  logic        mem_enable;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  word_offset;
  logic        write_tag_array;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_busy       (memory_busy),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .mem_enable        (mem_enable),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .word_offset       (word_offset),
    .write_tag_array   (write_tag_array)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int lat = 3;
  int gap = 0;
  int last_ret = -100;
  int pend[$];
  logic [15:0] exp_addr[$];
  logic [2:0]  exp_off[$];

  // One cycle: inputs applied just after the rising edge, outputs sampled on the falling edge.
  task automatic tick(input logic m, input logic [15:0] a, input logic b, input logic r);
    @(posedge clk);
    cyc++;
    #1;
    miss_detected     = m;
    miss_address      = a;
    memory_busy       = b;
    rst               = r;
    memory_data_valid = 1'b0;
    if (pend.size() > 0) begin
      if (pend[0] <= cyc && cyc > last_ret + gap) begin
        memory_data_valid = 1'b1;
        void'(pend.pop_front());
        last_ret = cyc;
      end
    end
    @(negedge clk);
    if (mem_enable === 1'b1) pend.push_back(cyc + lat);
  endtask

  // Accepts a miss (accept cycle = k0) and runs the fill to its tag pulse, scoring every issue and return.
  task automatic run_fill(input logic [15:0] addr, input int gp, input logic hold,
                          output int tag_k, output int first_iss, output int last_iss,
                          output int first_ret, output int nret, output logic [15:0] max_addr);
    logic [15:0] base;
    logic [15:0] ea;
    logic [2:0]  eo;
    logic        exp_tag;
    bit          done;
    gap = gp;
    exp_addr.delete();
    exp_off.delete();
    tag_k = -1; first_iss = -1; last_iss = -1; first_ret = -1; nret = 0; max_addr = '0;
    tick(1'b1, addr, 1'b0, 1'b0);
    tests++;
    if (fsm_busy !== 1'b0) begin
      failed++;
      $display("FAIL accept_idle addr=%h fsm_busy=%b want 0", addr, fsm_busy);
    end
    base = addr & 16'hFFF0;
    for (int i = 0; i < 8; i++) begin
      exp_addr.push_back(base + 16'(2 * i));
      exp_off.push_back(3'(i));
    end
    done = 0;
    for (int k = 1; k <= 60 && !done; k++) begin
      tick(hold, addr, 1'b0, 1'b0);
      tests++;
      if (fsm_busy !== 1'b1) begin
        failed++;
        $display("FAIL fill_busy k=%0d fsm_busy=%b want 1", k, fsm_busy);
      end
      if (mem_enable === 1'b1) begin
        if (first_iss < 0) first_iss = k;
        last_iss = k;
        if (memory_address > max_addr) max_addr = memory_address;
        tests++;
        if (exp_addr.size() == 0) begin
          failed++;
          $display("FAIL extra_issue k=%0d addr=%h want no issue", k, memory_address);
        end else begin
          ea = exp_addr.pop_front();
          if (memory_address !== ea) begin
            failed++;
            $display("FAIL issue_addr k=%0d got %h want %h", k, memory_address, ea);
          end
        end
      end else begin
        tests++;
        if (memory_address !== 16'h0000) begin
          failed++;
          $display("FAIL idle_addr k=%0d got %h want 0000", k, memory_address);
        end
      end
      exp_tag = 1'b0;
      if (write_data_array === 1'b1) begin
        if (first_ret < 0) first_ret = k;
        nret++;
        tests++;
        if (exp_off.size() == 0) begin
          failed++;
          $display("FAIL extra_write k=%0d offset=%0d want no write", k, word_offset);
        end else begin
          eo = exp_off.pop_front();
          if (word_offset !== eo) begin
            failed++;
            $display("FAIL word_offset k=%0d got %0d want %0d", k, word_offset, eo);
          end
          exp_tag = (exp_off.size() == 0);
        end
      end
      tests++;
      if (write_tag_array !== exp_tag) begin
        failed++;
        $display("FAIL tag_pulse k=%0d got %b want %b", k, write_tag_array, exp_tag);
      end
      if (write_tag_array === 1'b1) begin
        tag_k = k;
        done = 1;
      end
    end
    tests++;
    if (tag_k < 0) begin
      failed++;
      $display("FAIL fill_timeout addr=%h tag never seen, want pulse", addr);
    end
    gap = 0;
  endtask

  task automatic test_reset();
    tick(1'b0, 16'h0, 1'b0, 1'b1);
    tick(1'b0, 16'h0, 1'b0, 1'b1);
    tick(1'b0, 16'h0, 1'b0, 1'b0);
    tests++;
    if ({fsm_busy, mem_enable, write_data_array, write_tag_array} !== 4'b0000) begin
      failed++;
      $display("FAIL reset_flags got %b want 0000",
               {fsm_busy, mem_enable, write_data_array, write_tag_array});
    end
    tests++;
    if (memory_address !== 16'h0000) begin
      failed++;
      $display("FAIL reset_addr got %h want 0000", memory_address);
    end
    tests++;
    if (word_offset !== 3'd0) begin
      failed++;
      $display("FAIL reset_offset got %0d want 0", word_offset);
    end
  endtask

  task automatic test_basic_fill();
    int t, fi, li, fr, nr;
    logic [15:0] mx;
    run_fill(16'h1236, 0, 1'b0, t, fi, li, fr, nr, mx);
    tests++;
    if (fi !== 1 || li !== 8) begin
      failed++;
      $display("FAIL basic_issue_window got %0d..%0d want 1..8", fi, li);
    end
    tests++;
    if (fr !== 4 || nr !== 8) begin
      failed++;
      $display("FAIL basic_returns first=%0d n=%0d want first=4 n=8", fr, nr);
    end
    tests++;
    if (t !== 11) begin
      failed++;
      $display("FAIL basic_tag_cycle got %0d want 11", t);
    end
    tick(1'b0, 16'h0, 1'b0, 1'b0);
    tests++;
    if (fsm_busy !== 1'b0 || mem_enable !== 1'b0) begin
      failed++;
      $display("FAIL basic_done_c12 busy=%b en=%b want 0 0", fsm_busy, mem_enable);
    end
  endtask

  task automatic test_memory_busy();
    int t, fi, li, fr, nr;
    logic [15:0] mx;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 16'h004A, 1'b1, 1'b0);
      tests++;
      if (fsm_busy !== 1'b0 || mem_enable !== 1'b0) begin
        failed++;
        $display("FAIL busy_hold i=%0d busy=%b en=%b want 0 0", i, fsm_busy, mem_enable);
      end
    end
    run_fill(16'h004A, 0, 1'b1, t, fi, li, fr, nr, mx);
    tests++;
    if (fi !== 1) begin
      failed++;
      $display("FAIL busy_first_issue got k=%0d want 1", fi);
    end
  endtask

  task automatic test_top_of_memory();
    int t, fi, li, fr, nr;
    logic [15:0] mx;
    run_fill(16'hFFFF, 0, 1'b0, t, fi, li, fr, nr, mx);
    tests++;
    if (mx !== 16'hFFFE) begin
      failed++;
      $display("FAIL top_max_addr got %h want FFFE", mx);
    end
    tests++;
    if (nr !== 8 || t !== 11) begin
      failed++;
      $display("FAIL top_tag got n=%0d tag=%0d want n=8 tag=11", nr, t);
    end
  endtask

  task automatic test_reset_mid_fill();
    int strays;
    int t, fi, li, fr, nr;
    logic [15:0] mx;
    tick(1'b1, 16'h3010, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) tick(1'b0, 16'h3010, 1'b0, 1'b0);
    tick(1'b0, 16'h3010, 1'b0, 1'b1);
    strays = 0;
    tick(1'b0, 16'h0, 1'b0, 1'b0);
    if (memory_data_valid === 1'b1) strays++;
    tests++;
    if ({fsm_busy, mem_enable, write_data_array, write_tag_array} !== 4'b0000 ||
        memory_address !== 16'h0000 || word_offset !== 3'd0) begin
      failed++;
      $display("FAIL rst_mid_outputs flags=%b addr=%h off=%0d want all 0",
               {fsm_busy, mem_enable, write_data_array, write_tag_array}, memory_address, word_offset);
    end
    for (int j = 0; j < 20 && pend.size() > 0; j++) begin
      tick(1'b0, 16'h0, 1'b0, 1'b0);
      if (memory_data_valid === 1'b1) strays++;
      tests++;
      if (write_data_array !== 1'b0 || write_tag_array !== 1'b0) begin
        failed++;
        $display("FAIL stray_write j=%0d wda=%b tag=%b want 0 0", j, write_data_array, write_tag_array);
      end
    end
    tests++;
    if (strays !== 3) begin
      failed++;
      $display("FAIL stray_count got %0d want 3", strays);
    end
    run_fill(16'h2000, 0, 1'b0, t, fi, li, fr, nr, mx);
    tests++;
    if (t !== 11 || fr !== 4) begin
      failed++;
      $display("FAIL refill_after_rst tag=%0d first_ret=%0d want 11 4", t, fr);
    end
  endtask

  task automatic test_back_to_back();
    int t, fi, li, fr, nr;
    logic [15:0] mx;
    run_fill(16'h1000, 0, 1'b1, t, fi, li, fr, nr, mx);
    run_fill(16'h5008, 0, 1'b1, t, fi, li, fr, nr, mx);
    tests++;
    if (fi !== 1 || t !== 11) begin
      failed++;
      $display("FAIL b2b_second first_issue=%0d tag=%0d want 1 11", fi, t);
    end
  endtask

  task automatic test_gapped_returns();
    int t, fi, li, fr, nr;
    logic [15:0] mx;
    run_fill(16'h0800, 2, 1'b0, t, fi, li, fr, nr, mx);
    tests++;
    if (t !== 25 || nr !== 8) begin
      failed++;
      $display("FAIL gap_tag tag=%0d n=%0d want 25 8", t, nr);
    end
  endtask

  task automatic test_idle_valid();
    int t, fi, li, fr, nr;
    logic [15:0] mx;
    pend.push_back(cyc + 1);
    tick(1'b0, 16'h0, 1'b0, 1'b0);
    tests++;
    if (write_data_array !== 1'b0 || write_tag_array !== 1'b0 || word_offset !== 3'd0) begin
      failed++;
      $display("FAIL idle_valid wda=%b tag=%b off=%0d want 0 0 0", write_data_array, write_tag_array, word_offset);
    end
    run_fill(16'h0100, 0, 1'b0, t, fi, li, fr, nr, mx);
    tests++;
    if (t !== 11) begin
      failed++;
      $display("FAIL idle_valid_refill tag=%0d want 11", t);
    end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    miss_detected = 1'b0;
    miss_address = '0;
    memory_busy = 1'b0;
    memory_data_valid = 1'b0;
    test_reset();
    test_basic_fill();
    test_memory_busy();
    test_top_of_memory();
    test_reset_mid_fill();
    test_back_to_back();
    test_gapped_returns();
    test_idle_valid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
